me_reg: RTL and testbench

- Pipeline register between the Execute and Memory stages of the pipelined CPU.
- Captures the EX-stage opcode, function code, ALU result, destination register index and register-write flag on each enabled rising clock edge.
- Presents the captured values to the Memory stage as ME_* outputs.
- Purely a storage element: no decoding or arithmetic.

---
 rtl/me_reg_pkg.sv | 22 ++
 rtl/me_reg_pipe_field_reg.sv | 42 ++++
 rtl/me_reg.sv | 80 ++++++++
 tb/tb_me_reg.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/me_reg_pkg.sv
// ---------------------------------------------------------------------------
// me_reg_pkg
// Shared constants for the Execute->Memory pipeline register.
//   OP_ALUR / FN_ADD      : opcode and function code of a register-register add
//   DEFAULT_DBITS         : default data/result path width
//   DEFAULT_REG_IDX_BITS  : default register-file index width
// ---------------------------------------------------------------------------
package me_reg_pkg;

  localparam logic [3:0] OP_ALUR = 4'b1100;
  localparam logic [3:0] FN_ADD  = 4'b0111;

  localparam int DEFAULT_DBITS        = 32;
  localparam int DEFAULT_REG_IDX_BITS = 4;

  // True when an op/func pair encodes a register-register add. The pipeline
  // register itself never decodes; this is for consumers of the package.
  function automatic logic is_alur_add(input logic [3:0] op, input logic [3:0] func);
    return (op == OP_ALUR) && (func == FN_ADD);
  endfunction

endpackage : me_reg_pkg

// File: rtl/me_reg_pipe_field_reg.sv
// ---------------------------------------------------------------------------
// pipe_field_reg
// Parameterized-width enabled register with asynchronous active-low clear.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear, forces q to 0 immediately
//   en    : 1 = load d at the edge, 0 = hold
//   d     : next value
//   q     : registered value, driven straight from the flop
// ---------------------------------------------------------------------------
module pipe_field_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = d;
    end
  end

  // Clear is asynchronous so a flushed stage becomes a bubble without
  // waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule : pipe_field_reg

// File: rtl/me_reg.sv
// ---------------------------------------------------------------------------
// me_reg
// Pipeline register between the Execute and Memory stages. Captures the EX
// opcode, function code, ALU result, destination index and write flag on an
// enabled rising edge and presents them as ME_* outputs. Pure storage.
//   wrt_en    : 1 = capture all fields, 0 = hold all fields (stall)
//   reset     : asynchronous active-low clear of every field
//   clk       : rising-edge clock
//   op, func  : EX-stage opcode / function code (4 bits each)
//   result    : EX-stage ALU result (DBITS)
//   rd        : destination register index (REG_INDEX_BIT_WIDTH)
//   wrReg     : register-file write request
//   ME_*      : registered copies of the above, no combinational input path
// ---------------------------------------------------------------------------
module me_reg
  import me_reg_pkg::*;
#(
  parameter int DBITS               = DEFAULT_DBITS,
  parameter int REG_INDEX_BIT_WIDTH = DEFAULT_REG_IDX_BITS
) (
  input  logic                           wrt_en,
  input  logic                           reset,
  input  logic                           clk,
  input  logic [3:0]                     op,
  input  logic [3:0]                     func,
  input  logic [DBITS-1:0]               result,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] rd,
  input  logic                           wrReg,
  output logic [3:0]                     ME_func,
  output logic [3:0]                     ME_op,
  output logic [DBITS-1:0]               ME_result,
  output logic [REG_INDEX_BIT_WIDTH-1:0] ME_rd,
  output logic                           ME_wrReg
);

  // One shared enable for every field keeps the stage coherent: a stall
  // never lets one field advance while another holds.

  pipe_field_reg #(.WIDTH(4)) u_op_reg (
    .clk   (clk),
    .rst_n (reset),
    .en    (wrt_en),
    .d     (op),
    .q     (ME_op)
  );

  pipe_field_reg #(.WIDTH(4)) u_func_reg (
    .clk   (clk),
    .rst_n (reset),
    .en    (wrt_en),
    .d     (func),
    .q     (ME_func)
  );

  pipe_field_reg #(.WIDTH(DBITS)) u_result_reg (
    .clk   (clk),
    .rst_n (reset),
    .en    (wrt_en),
    .d     (result),
    .q     (ME_result)
  );

  pipe_field_reg #(.WIDTH(REG_INDEX_BIT_WIDTH)) u_rd_reg (
    .clk   (clk),
    .rst_n (reset),
    .en    (wrt_en),
    .d     (rd),
    .q     (ME_rd)
  );

  // Clearing wrReg on reset is what turns the flushed stage into a bubble.
  pipe_field_reg #(.WIDTH(1)) u_wrreg_reg (
    .clk   (clk),
    .rst_n (reset),
    .en    (wrt_en),
    .d     (wrReg),
    .q     (ME_wrReg)
  );

endmodule : me_reg

// File: tb/tb_me_reg.sv
module tb_me_reg;
  import me_reg_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  func;
    logic [31:0] result;
    logic [3:0]  rd;
    logic        wr;
  } me_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        wrt_en;
  logic [3:0]  op, func, rd;
  logic [31:0] result;
  logic        wrReg;
  logic [3:0]  ME_func, ME_op, ME_rd;
  logic [31:0] ME_result;
  logic        ME_wrReg;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  me_t model;
  me_t sb_q[$];

  always #5 clk = ~clk;

  me_reg #(.DBITS(32), .REG_INDEX_BIT_WIDTH(4)) dut (
    .wrt_en    (wrt_en),
    .reset     (reset),
    .clk       (clk),
    .op        (op),
    .func      (func),
    .result    (result),
    .rd        (rd),
    .wrReg     (wrReg),
    .ME_func   (ME_func),
    .ME_op     (ME_op),
    .ME_result (ME_result),
    .ME_rd     (ME_rd),
    .ME_wrReg  (ME_wrReg)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic clear_model();
    model.op = '0; model.func = '0; model.result = '0; model.rd = '0; model.wr = 1'b0;
  endtask

  // Pop one expected entry and compare every output field against it.
  task automatic compare_out(input string tag);
    me_t e;
    if (sb_q.size() == 0) begin
      check_val({tag, ".sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb_q.pop_front();
    check_val({tag, ".op"},     {60'd0, ME_op},     {60'd0, e.op});
    check_val({tag, ".func"},   {60'd0, ME_func},   {60'd0, e.func});
    check_val({tag, ".result"}, {32'd0, ME_result}, {32'd0, e.result});
    check_val({tag, ".rd"},     {60'd0, ME_rd},     {60'd0, e.rd});
    check_val({tag, ".wrReg"},  {63'd0, ME_wrReg},  {63'd0, e.wr});
    $display("txn %-10s op=%b func=%b result=%h rd=%0d wrReg=%b", tag,
             ME_op, ME_func, ME_result, ME_rd, ME_wrReg);
  endtask

  // Drive inputs at the falling edge, predict, then sample 1ns after the rising edge.
  task automatic edge_txn(input string tag, input logic we, input logic [3:0] o,
                          input logic [3:0] f, input logic [31:0] r,
                          input logic [3:0] d, input logic w);
    @(negedge clk);
    wrt_en = we; op = o; func = f; result = r; rd = d; wrReg = w;
    if (reset && we) begin
      model.op = o; model.func = f; model.result = r; model.rd = d; model.wr = w;
    end
    sb_q.push_back(model);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  initial begin
    clear_model();
    reset = 1'b0; wrt_en = 1'b0; op = '0; func = '0; result = '0; rd = '0; wrReg = 1'b0;

    // 1: reset held low across an enabled edge
    #2;
    sb_q.push_back(model);
    compare_out("rst_init");
    edge_txn("rst_hold", 1'b1, OP_ALUR, FN_ADD, 32'd2, 4'd3, 1'b1);

    // 2: release reset, then capture
    @(negedge clk);
    reset = 1'b1;
    edge_txn("capture", 1'b1, OP_ALUR, FN_ADD, 32'd2, 4'd3, 1'b1);
    check_val("pkg_alur_add", {63'd0, is_alur_add(ME_op, ME_func)}, 64'd1);

    // no combinational path: change inputs mid-cycle, outputs unchanged
    #2;
    result = 32'hDEAD_BEEF; rd = 4'd9; op = 4'd1;
    #1;
    sb_q.push_back(model);
    compare_out("no_comb");

    // 3: stall
    edge_txn("stall", 1'b0, OP_ALUR, FN_ADD, 32'd5, 4'd1, 1'b1);

    // 4: async reset between edges
    #2;
    reset = 1'b0;
    #1;
    clear_model();
    sb_q.push_back(model);
    compare_out("async_rst");
    edge_txn("rst_edge", 1'b1, 4'hF, 4'hF, 32'h1234_5678, 4'hF, 1'b1);
    @(negedge clk);
    reset = 1'b1;

    // 5: bubble propagation and full-width value
    edge_txn("load", 1'b1, OP_ALUR, FN_ADD, 32'd2, 4'd3, 1'b1);
    edge_txn("bubble", 1'b1, OP_ALUR, FN_ADD, 32'd5, 4'd3, 1'b0);
    edge_txn("full_w", 1'b1, OP_ALUR, FN_ADD, 32'hFFFF_FFFF, 4'hF, 1'b1);

    // Random mix of captures and stalls
    for (int i = 0; i < 16; i++) begin
      edge_txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 4'($urandom),
               4'($urandom), $urandom, 4'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_me_reg
